// File: rtl/qspi_slave_rx.sv
// Receive-only QSPI slave: oversampled QSS/QCK/QD, nibble-to-byte assembly (high nibble first),
// byte FIFO with valid/ready read side and frame status.
module qspi_slave_rx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          io_mainClk,
  input  logic                          io_resetn,
  input  logic                          io_qss,
  input  logic                          io_qck,
  input  logic [3:0]                    io_qd,
  output logic                          io_rsp_valid,
  input  logic                          io_rsp_ready,
  output logic [7:0]                    io_rsp_payload_data,
  output logic                          io_rsp_payload_first,
  output logic                          io_frameActive,
  output logic                          io_frameDone,
  output logic                          io_frameError,
  output logic                          io_overflow,
  input  logic                          io_overflowClear,
  output logic [15:0]                   io_byteCount,
  output logic [$clog2(FIFO_DEPTH):0]   io_occupancy
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic       first;
    logic [7:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, HI, LO} state_t;

  // All three line groups share one chain so synced data stays aligned with synced clock.
  logic [SYNC_STAGES-1:0][5:0] sync_q;
  logic qss_s, qck_s, qss_prev, qck_prev;
  logic [3:0] qd_s;
  logic qck_rise, qss_fall, qss_rise;

  always_ff @(posedge io_mainClk) begin
    if (!io_resetn) begin
      sync_q   <= '0;
      qss_prev <= 1'b0;
      qck_prev <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], {io_qss, io_qck, io_qd}};
      qss_prev <= qss_s;
      qck_prev <= qck_s;
    end
  end

  assign qss_s    = sync_q[SYNC_STAGES-1][5];
  assign qck_s    = sync_q[SYNC_STAGES-1][4];
  assign qd_s     = sync_q[SYNC_STAGES-1][3:0];
  assign qck_rise = qck_s & ~qck_prev;
  assign qss_fall = ~qss_s & qss_prev;
  assign qss_rise = qss_s & ~qss_prev;

  state_t state_q, state_d;
  logic push, frame_start, done, err;

  always_ff @(posedge io_mainClk) begin
    if (!io_resetn) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // qssRise is tested first so a coincident QCK edge is dropped.
  always_comb begin
    state_d     = state_q;
    push        = 1'b0;
    frame_start = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    unique case (state_q)
      IDLE: if (qss_fall) begin
        state_d     = HI;
        frame_start = 1'b1;
      end
      HI: if (qss_rise) begin
        state_d = IDLE;
        done    = 1'b1;
      end else if (qck_rise) begin
        state_d = LO;
      end
      LO: if (qss_rise) begin
        state_d = IDLE;
        done    = 1'b1;
        err     = 1'b1;
      end else if (qck_rise) begin
        state_d = HI;
        push    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  logic [3:0] hi_nib;
  logic       first_pending;

  always_ff @(posedge io_mainClk) begin
    if (!io_resetn) begin
      hi_nib        <= '0;
      first_pending <= 1'b0;
      io_byteCount  <= '0;
    end else begin
      if (state_q == HI && qck_rise && !qss_rise) hi_nib <= qd_s;
      if (frame_start)   first_pending <= 1'b1;
      else if (push)     first_pending <= 1'b0;
      if (frame_start)   io_byteCount <= '0;
      else if (push && io_byteCount != 16'hFFFF) io_byteCount <= io_byteCount + 16'd1;
    end
  end

  entry_t            mem [FIFO_DEPTH];
  entry_t            head;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              full, pop, wr_en;

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign pop   = io_rsp_valid & io_rsp_ready;
  assign wr_en = push & (~full | pop);

  always_ff @(posedge io_mainClk) begin
    if (wr_en) mem[wr_ptr] <= '{first: first_pending, data: {hi_nib, qd_s}};
  end

  always_ff @(posedge io_mainClk) begin
    if (!io_resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      io_overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop)  io_overflow <= 1'b1;
      else if (io_overflowClear) io_overflow <= 1'b0;
    end
  end

  // Head is masked while empty so stale or uninitialised storage never leaks out.
  assign head                 = mem[rd_ptr];
  assign io_rsp_valid         = (count != '0);
  assign io_rsp_payload_data  = io_rsp_valid ? head.data  : 8'h00;
  assign io_rsp_payload_first = io_rsp_valid ? head.first : 1'b0;
  assign io_occupancy         = count;
  assign io_frameActive       = (state_q != IDLE);
  assign io_frameDone         = done;
  assign io_frameError        = err;
endmodule

// File: tb/tb_qspi_slave_rx.sv
// Bench for qspi_slave_rx: reset state, table of directed frames, multi-cycle corner sequences,
// and random frames with random consumer backpressure scored against a frame-level model.
module tb_qspi_slave_rx;
  localparam int DEPTH = 16;
  localparam int SYNC  = 2;

  logic        clk = 1'b0, resetn = 1'b0, qss = 1'b1, qck = 1'b0, ovf_clr = 1'b0;
  logic [3:0]  qd = 4'h0;
  logic        rsp_ready = 1'b0;
  logic        rsp_valid, rsp_first, frame_active, frame_done, frame_error, overflow;
  logic [7:0]  rsp_data;
  logic [15:0] byte_count;
  logic [4:0]  occupancy;

  qspi_slave_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .io_mainClk(clk), .io_resetn(resetn), .io_qss(qss), .io_qck(qck), .io_qd(qd),
    .io_rsp_valid(rsp_valid), .io_rsp_ready(rsp_ready), .io_rsp_payload_data(rsp_data),
    .io_rsp_payload_first(rsp_first), .io_frameActive(frame_active),
    .io_frameDone(frame_done), .io_frameError(frame_error), .io_overflow(overflow),
    .io_overflowClear(ovf_clr), .io_byteCount(byte_count), .io_occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int done_cnt = 0, err_cnt = 0, err_alone = 0;
  bit ready_rand = 1'b0, ready_val = 1'b0;
  logic [8:0] rx_q[$];
  logic [8:0] exp_q[$];
  logic [3:0] tx_q[$];

  // Single driver of the consumer ready line.
  always @(posedge clk) begin
    #3;
    rsp_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
  end

  // Record accepted bytes and status pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (resetn) begin
      if (rsp_valid && rsp_ready) rx_q.push_back({rsp_first, rsp_data});
      if (frame_done) done_cnt++;
      if (frame_error) err_cnt++;
      if (frame_error && !frame_done) err_alone++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_nib(input logic [3:0] n);
    qd = n;
    tick(4);
    qck = 1'b1;
    tick(4);
    qck = 1'b0;
  endtask

  task automatic send_frame();
    qss = 1'b0;
    tick(8);
    foreach (tx_q[i]) send_nib(tx_q[i]);
    tick(4);
    qss = 1'b1;
    tick(8);
  endtask

  // Frame-level model: consecutive nibble pairs form bytes, only byte 0 carries first.
  task automatic model_frame();
    exp_q.delete();
    for (int k = 0; k < tx_q.size() / 2; k++)
      exp_q.push_back({k == 0, tx_q[2*k], tx_q[2*k+1]});
  endtask

  task automatic check_frame(input string nm, input int exp_cnt, input bit exp_err,
                             input int d0, input int e0);
    ready_rand = 1'b0;
    ready_val  = 1'b1;
    tick(24);
    check({nm, " nbytes"}, rx_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++)
      check({nm, " byte"}, rx_q[k], exp_q[k]);
    check({nm, " byteCount"}, byte_count, exp_cnt);
    check({nm, " frameDone"}, done_cnt - d0, 1);
    check({nm, " frameError"}, err_cnt - e0, exp_err);
    check({nm, " drained"}, occupancy, 0);
    rx_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    int          n;
    logic [31:0] nibs;
    int          cnt;
    bit          err;
    logic [15:0] bytes;
  } vec_t;

  vec_t vt[5];

  initial begin
    int d0, e0;
    logic [15:0] bb;
    logic [31:0] nn;
    logic [7:0]  b;

    vt[0] = '{n: 4, nibs: 32'hA53C_0000, cnt: 2, err: 1'b0, bytes: 16'hA53C};
    vt[1] = '{n: 3, nibs: 32'h1270_0000, cnt: 1, err: 1'b1, bytes: 16'h1200};
    vt[2] = '{n: 0, nibs: 32'h0000_0000, cnt: 0, err: 1'b0, bytes: 16'h0000};
    vt[3] = '{n: 1, nibs: 32'hF000_0000, cnt: 0, err: 1'b1, bytes: 16'h0000};
    vt[4] = '{n: 2, nibs: 32'h0000_0000, cnt: 1, err: 1'b0, bytes: 16'h0000};

    // Reset state
    tick(3);
    check("reset valid", rsp_valid, 0);
    check("reset data", rsp_data, 0);
    check("reset first", rsp_first, 0);
    check("reset active", frame_active, 0);
    check("reset done", frame_done, 0);
    check("reset error", frame_error, 0);
    check("reset overflow", overflow, 0);
    check("reset byteCount", byte_count, 0);
    check("reset occupancy", occupancy, 0);
    resetn = 1'b1;
    tick(5);

    // Directed frames from the table
    ready_val = 1'b1;
    for (int v = 0; v < 5; v++) begin
      tx_q.delete();
      nn = vt[v].nibs;
      for (int i = 0; i < vt[v].n; i++) tx_q.push_back(nn[31-4*i -: 4]);
      exp_q.delete();
      bb = vt[v].bytes;
      for (int k = 0; k < vt[v].cnt; k++) exp_q.push_back({k == 0, bb[15-8*k -: 8]});
      d0 = done_cnt; e0 = err_cnt;
      send_frame();
      check_frame($sformatf("vec%0d", v), vt[v].cnt, vt[v].err, d0, e0);
    end

    // Push latency measured from the first edge that samples the low-nibble QCK high
    ready_val = 1'b0;
    d0 = done_cnt; e0 = err_cnt;
    qss = 1'b0;
    tick(8);
    send_nib(4'hA);
    qd = 4'h5;
    tick(4);
    qck = 1'b1;
    @(posedge clk); #1;
    check("latency edge0 valid", rsp_valid, 0);
    @(posedge clk); #1;
    check("latency edge1 valid", rsp_valid, 0);
    @(posedge clk); #1;
    check("latency edge2 valid", rsp_valid, 1);
    tick(2);
    qck = 1'b0;
    tick(4);
    qss = 1'b1;
    tick(8);
    exp_q.delete();
    exp_q.push_back({1'b1, 8'hA5});
    check_frame("latency", 1, 1'b0, d0, e0);

    // Overflow: 18 bytes into a 16-entry FIFO with no consumer
    ready_val = 1'b0;
    tx_q.delete();
    for (int i = 0; i < 18; i++) begin
      b = 8'(i * 7 + 3);
      tx_q.push_back(b[7:4]);
      tx_q.push_back(b[3:0]);
    end
    model_frame();
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    d0 = done_cnt; e0 = err_cnt;
    send_frame();
    check("ovf occupancy", occupancy, DEPTH);
    check("ovf flag", overflow, 1);
    check("ovf byteCount", byte_count, 18);
    check_frame("ovf", 18, 1'b0, d0, e0);
    check("ovf sticky", overflow, 1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    tick(1);
    check("ovf cleared", overflow, 0);

    // Full FIFO: the 17th push lands on the cycle of a pop
    ready_val = 1'b0;
    d0 = done_cnt; e0 = err_cnt;
    qss = 1'b0;
    tick(8);
    for (int i = 0; i < 16; i++) begin
      b = 8'(8'h40 + i);
      send_nib(b[7:4]);
      send_nib(b[3:0]);
    end
    check("full before push", occupancy, DEPTH);
    send_nib(4'h5);
    qd = 4'h0;
    tick(4);
    qck = 1'b1;
    tick(1);
    tick(1);
    ready_val = 1'b1;
    tick(1);
    ready_val = 1'b0;
    check("full+pop occupancy", occupancy, DEPTH);
    check("full+pop overflow", overflow, 0);
    tick(2);
    qck = 1'b0;
    tick(4);
    qss = 1'b1;
    tick(8);
    check("full+pop overflow end", overflow, 0);
    exp_q.delete();
    for (int i = 0; i < 17; i++) exp_q.push_back({i == 0, 8'(8'h40 + i)});
    check_frame("full+pop", 17, 1'b0, d0, e0);

    // Reset in the middle of a frame while QSS stays low
    ready_val = 1'b0;
    d0 = done_cnt;
    qss = 1'b0;
    tick(8);
    for (int i = 1; i <= 6; i++) send_nib(4'(i));
    check("midreset pre occupancy", occupancy, 3);
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) send_nib(4'hE);
    check("midreset occupancy", occupancy, 0);
    check("midreset valid", rsp_valid, 0);
    check("midreset byteCount", byte_count, 0);
    check("midreset active", frame_active, 0);
    qss = 1'b1;
    tick(8);
    check("midreset no done", done_cnt - d0, 0);
    tx_q.delete();
    tx_q.push_back(4'h9);
    tx_q.push_back(4'h9);
    model_frame();
    d0 = done_cnt; e0 = err_cnt;
    send_frame();
    check_frame("after reset", 1, 1'b0, d0, e0);

    // Random frames under random backpressure
    for (int r = 0; r < 20; r++) begin
      int n;
      tx_q.delete();
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) tx_q.push_back(4'($urandom_range(0, 15)));
      model_frame();
      d0 = done_cnt; e0 = err_cnt;
      ready_rand = 1'b1;
      send_frame();
      check_frame($sformatf("rand%0d", r), n / 2, n % 2 == 1, d0, e0);
    end

    check("error without done", err_alone, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
